mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipelined MIPS. Sits between the EX/MEM control/data outputs and the WB stage.
- Issues loads and stores to a variable-latency data memory over a req/ack handshake.
- Stalls upstream stages while an access is outstanding, and registers the MEM/WB pipeline fields.
- Flags misaligned word addresses and bus timeouts.

Parameters:
- N, 32, datapath width.
- N_REG_ADDR, 5, register-file address width.
- TIMEOUT, 16, maximum number of WAIT cycles before an access is aborted. Must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a real instruction; 0 means bubble
- ex_alu_result  in  N  effective address, or ALU result for non-memory ops
- ex_write_data  in  N  store data (rt)
- ex_write_reg  in  N_REG_ADDR  destination register
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_mem_to_reg  in  1  WB selects read data
- ex_reg_write  in  1  WB writes register file
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  N  word-aligned byte address
- dmem_wdata  out  N  store data
- dmem_ack  in  1  access complete; dmem_rdata valid this cycle
- dmem_rdata  in  N  load data
- wb_valid  out  1  MEM/WB holds a retired instruction
- wb_reg_write  out  1  register-file write enable
- wb_mem_to_reg  out  1  WB mux select
- wb_write_reg  out  N_REG_ADDR  destination register
- wb_alu_result  out  N  registered ALU result
- wb_read_data  out  N  registered load data
- misalign_err  out  1  one-cycle pulse
- bus_err  out  1  one-cycle pulse

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs 0, including mem_stall and dmem_req. Reset asserted mid-WAIT drops dmem_req at the next edge; any late dmem_ack is ignored.
- State machine has two states, IDLE and WAIT. mem_stall = (state == WAIT), decoded directly from the state register.
- IDLE, ex_valid = 0: next cycle wb_valid = 0, wb_reg_write = 0. Other wb fields are don't-care, but the bench expects 0.
- IDLE, ex_valid = 1, no memory op: one-cycle latency. Next cycle:
  - wb_valid = 1.
  - wb_* take the corresponding ex_* values.
  - wb_read_data = 0.
- IDLE, memory op, ex_alu_result[1:0] != 0:
  - No request is issued and there is no stall.
  - Next cycle: wb_valid = 1, wb_reg_write = 0, misalign_err = 1 for one cycle.
- IDLE, memory op, aligned:
  - Capture address, we (= ex_mem_write), wdata and control fields. Go to WAIT.
  - Next cycle: dmem_req = 1, wb_valid = 0.
  - If both ex_mem_read and ex_mem_write are set, treat it as a store.
  - The instruction is consumed at this edge; the upstream stage may advance.
- WAIT:
  - mem_stall = 1. dmem_req, dmem_we, dmem_addr and dmem_wdata stay stable.
  - ex_* inputs are ignored; upstream holds them.
  - wb_valid = 0 each WAIT cycle.
- WAIT, ack handling: dmem_ack is sampled on every WAIT edge, and the counter increments on each WAIT cycle without ack. On the edge where dmem_ack = 1, the next cycle has:
  - State IDLE, dmem_req = 0, mem_stall = 0.
  - wb_valid = 1 and wb_* from the captured fields.
  - wb_read_data = dmem_rdata for loads, 0 for stores.
  - At this point the held upstream instruction is presented and handled as in IDLE.
- Timeout:
  - If the counter reaches TIMEOUT with dmem_ack = 0 (after TIMEOUT WAIT cycles), abort.
  - Next cycle: dmem_req = 0, state IDLE, wb_valid = 1, wb_reg_write = 0, bus_err = 1 for one cycle. Counter clears.
  - dmem_req is therefore high for exactly TIMEOUT cycles.
  - dmem_ack arriving on the TIMEOUT-th cycle: ack wins and completes normally.
- dmem_ack while IDLE is ignored.
- Best-case throughput: one memory op per 2 cycles (ack on first WAIT cycle). Non-memory ops run at one per cycle.
- Counter width is clog2(TIMEOUT+1). No wrap is possible, because abort fires first.

Test Plan:
- Reset, ALU op: reset held 2 cycles, then ex_valid = 1, reg_write = 1, alu_result = 0x0000_00AA, write_reg = 9 -> next cycle wb_valid = 1, wb_alu_result = 0xAA, wb_write_reg = 9, mem_stall = 0. All outputs 0 during reset.
- Load, ack after 3 WAIT cycles: load addr 0x100, dmem_ack high on the 3rd req cycle with rdata = 0xDEADBEEF -> dmem_req high exactly 3 cycles, mem_stall high exactly 3 cycles, then wb_valid = 1, wb_read_data = 0xDEADBEEF, wb_mem_to_reg = 1.
- Store, immediate ack, then ALU op: store addr 0x204, data 0x1234 -> dmem_we = 1, addr = 0x204, wdata = 0x1234 for 1 cycle. Then the ALU op retires the cycle after stall release; no instruction is lost or duplicated.
- Misaligned load: addr 0x102 -> no dmem_req, misalign_err pulse 1 cycle, wb_valid = 1, wb_reg_write = 0, mem_stall never asserted.
- Timeout: load with dmem_ack held 0 -> dmem_req high 16 cycles, bus_err = 1 on the 17th, wb_reg_write = 0. Second run with ack on the 16th cycle -> normal completion, no bus_err.
- Reset mid-WAIT: reset on the 2nd WAIT cycle -> dmem_req = 0 next cycle, state IDLE. dmem_ack pulsed afterwards -> no wb_valid.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores to a variable-latency data memory over a
// req/ack handshake, stalls upstream while an access is outstanding, and
// registers the MEM/WB pipeline fields. Flags misaligned and timed-out accesses.
module mem_access_stage #(
  parameter int N          = 32,
  parameter int N_REG_ADDR = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic [N-1:0]          ex_alu_result,
  input  logic [N-1:0]          ex_write_data,
  input  logic [N_REG_ADDR-1:0] ex_write_reg,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_reg_write,
  output logic                  mem_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [N-1:0]          dmem_addr,
  output logic [N-1:0]          dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [N-1:0]          dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [N_REG_ADDR-1:0] wb_write_reg,
  output logic [N-1:0]          wb_alu_result,
  output logic [N-1:0]          wb_read_data,
  output logic                  misalign_err,
  output logic                  bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                  state, state_d;
  logic [CW-1:0]           cnt, cnt_d;

  // Access captured when a memory op leaves IDLE; held stable through WAIT.
  logic                    we_q, we_d;
  logic [N-1:0]            addr_q, addr_d;
  logic [N-1:0]            wdata_q, wdata_d;
  logic [N_REG_ADDR-1:0]   cap_write_reg_q, cap_write_reg_d;
  logic                    cap_mem_to_reg_q, cap_mem_to_reg_d;
  logic                    cap_reg_write_q, cap_reg_write_d;
  logic                    cap_is_load_q, cap_is_load_d;

  logic                    wb_valid_d, wb_reg_write_d, wb_mem_to_reg_d;
  logic [N_REG_ADDR-1:0]   wb_write_reg_d;
  logic [N-1:0]            wb_alu_result_d, wb_read_data_d;
  logic                    misalign_d, bus_err_d;

  logic                    is_mem_op, is_aligned;

  assign is_mem_op  = ex_mem_read | ex_mem_write;
  assign is_aligned = (ex_alu_result[1:0] == 2'b00);

  // Stall and request are decoded straight from the state register.
  assign mem_stall  = (state == S_WAIT);
  assign dmem_req   = (state == S_WAIT);
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

  // Next-state and next-value logic for the FSM, counter, capture and MEM/WB fields.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d          = state;
    cnt_d            = cnt;
    we_d             = we_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    cap_write_reg_d  = cap_write_reg_q;
    cap_mem_to_reg_d = cap_mem_to_reg_q;
    cap_reg_write_d  = cap_reg_write_q;
    cap_is_load_d    = cap_is_load_q;
    wb_valid_d       = 1'b0;
    wb_reg_write_d   = 1'b0;
    wb_mem_to_reg_d  = 1'b0;
    wb_write_reg_d   = '0;
    wb_alu_result_d  = '0;
    wb_read_data_d   = '0;
    misalign_d       = 1'b0;
    bus_err_d        = 1'b0;

    case (state)
      S_IDLE: begin
        if (ex_valid) begin
          if (!is_mem_op) begin
            wb_valid_d      = 1'b1;
            wb_reg_write_d  = ex_reg_write;
            wb_mem_to_reg_d = ex_mem_to_reg;
            wb_write_reg_d  = ex_write_reg;
            wb_alu_result_d = ex_alu_result;
          end else if (!is_aligned) begin
            // Retire as a no-write instruction so the pipeline keeps moving.
            wb_valid_d = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d          = S_WAIT;
            cnt_d            = '0;
            we_d             = ex_mem_write;
            addr_d           = ex_alu_result;
            wdata_d          = ex_write_data;
            cap_write_reg_d  = ex_write_reg;
            cap_mem_to_reg_d = ex_mem_to_reg;
            cap_reg_write_d  = ex_reg_write;
            // Read+write together is treated as a store.
            cap_is_load_d    = ex_mem_read & ~ex_mem_write;
          end
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          // Ack wins even on the last allowed cycle.
          state_d         = S_IDLE;
          cnt_d           = '0;
          wb_valid_d      = 1'b1;
          wb_reg_write_d  = cap_reg_write_q;
          wb_mem_to_reg_d = cap_mem_to_reg_q;
          wb_write_reg_d  = cap_write_reg_q;
          wb_alu_result_d = addr_q;
          wb_read_data_d  = cap_is_load_q ? dmem_rdata : '0;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_d        = S_IDLE;
          cnt_d          = '0;
          wb_valid_d     = 1'b1;
          wb_write_reg_d = cap_write_reg_q;
          bus_err_d      = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, capture and MEM/WB registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state            <= S_IDLE;
      cnt              <= '0;
      we_q             <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      cap_write_reg_q  <= '0;
      cap_mem_to_reg_q <= 1'b0;
      cap_reg_write_q  <= 1'b0;
      cap_is_load_q    <= 1'b0;
      wb_valid         <= 1'b0;
      wb_reg_write     <= 1'b0;
      wb_mem_to_reg    <= 1'b0;
      wb_write_reg     <= '0;
      wb_alu_result    <= '0;
      wb_read_data     <= '0;
      misalign_err     <= 1'b0;
      bus_err          <= 1'b0;
    end else begin
      state            <= state_d;
      cnt              <= cnt_d;
      we_q             <= we_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      cap_write_reg_q  <= cap_write_reg_d;
      cap_mem_to_reg_q <= cap_mem_to_reg_d;
      cap_reg_write_q  <= cap_reg_write_d;
      cap_is_load_q    <= cap_is_load_d;
      wb_valid         <= wb_valid_d;
      wb_reg_write     <= wb_reg_write_d;
      wb_mem_to_reg    <= wb_mem_to_reg_d;
      wb_write_reg     <= wb_write_reg_d;
      wb_alu_result    <= wb_alu_result_d;
      wb_read_data     <= wb_read_data_d;
      misalign_err     <= misalign_d;
      bus_err          <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by
// random instructions with random memory latencies, checked against an
// instruction-level model (latency, stall length and retired fields).
module tb_mem_access_stage;

  localparam int N       = 32;
  localparam int NR      = 5;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid;
  logic [N-1:0]  ex_alu_result;
  logic [N-1:0]  ex_write_data;
  logic [NR-1:0] ex_write_reg;
  logic          ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write;
  logic          mem_stall, dmem_req, dmem_we;
  logic [N-1:0]  dmem_addr, dmem_wdata;
  logic          dmem_ack;
  logic [N-1:0]  dmem_rdata;
  logic          wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [NR-1:0] wb_write_reg;
  logic [N-1:0]  wb_alu_result, wb_read_data;
  logic          misalign_err, bus_err;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          valid;
    logic [N-1:0]  alu;
    logic [N-1:0]  wdata;
    logic [NR-1:0] wreg;
    logic          rd;
    logic          wr;
    logic          m2r;
    logic          rw;
  } instr_t;

  mem_access_stage #(.N(N), .N_REG_ADDR(NR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_write_reg(wb_write_reg),
    .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input instr_t ins);
    ex_valid      = ins.valid;
    ex_alu_result = ins.alu;
    ex_write_data = ins.wdata;
    ex_write_reg  = ins.wreg;
    ex_mem_read   = ins.rd;
    ex_mem_write  = ins.wr;
    ex_mem_to_reg = ins.m2r;
    ex_reg_write  = ins.rw;
  endtask

  function automatic instr_t mk(input logic v, input logic [N-1:0] a, input logic [N-1:0] d,
                                input logic [NR-1:0] r, input logic rd, input logic wr,
                                input logic m2r, input logic rw);
    instr_t i;
    i.valid = v; i.alu = a; i.wdata = d; i.wreg = r;
    i.rd = rd; i.wr = wr; i.m2r = m2r; i.rw = rw;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int kind;
    kind    = $urandom_range(0, 5);
    i.valid = (kind != 0);
    i.alu   = $urandom;
    i.wdata = $urandom;
    i.wreg  = NR'($urandom);
    i.m2r   = 1'($urandom);
    i.rw    = 1'($urandom);
    i.rd    = (kind == 2) || (kind == 4 && i.alu[0]) || (kind == 5) || (kind == 0 && i.alu[2]);
    i.wr    = (kind == 3) || (kind == 4 && !i.alu[0]) || (kind == 5);
    if (kind inside {2, 3, 5}) i.alu[1:0] = 2'b00;
    if (kind == 4 && i.alu[1:0] == 2'b00) i.alu[1] = 1'b1;
    return i;
  endfunction

  // Present one instruction in IDLE and follow it to retirement.
  // lat: ack arrives on the lat-th request cycle; lat > TIMEOUT means never.
  task automatic step(input instr_t ins, input int lat, input logic [N-1:0] rdata);
    logic          is_mem, is_aligned;
    logic [N-1:0]  exp_rdata;
    drive(ins);
    dmem_ack   = 1'($urandom);     // stray ack while idle must be ignored
    dmem_rdata = $urandom;
    @(posedge clk); #1;
    dmem_ack   = 1'b0;
    is_mem     = ins.valid && (ins.rd || ins.wr);
    is_aligned = (ins.alu[1:0] == 2'b00);
    if (is_mem && is_aligned) begin
      drive(rand_instr());         // upstream contents during the stall are ignored
      for (int k = 1; k <= TIMEOUT; k++) begin
        check("wait_req",   dmem_req,   1);
        check("wait_stall", mem_stall,  1);
        check("wait_we",    dmem_we,    ins.wr);
        check("wait_addr",  dmem_addr,  ins.alu);
        check("wait_wdata", dmem_wdata, ins.wdata);
        check("wait_wbv",   wb_valid,   0);
        if (k == lat) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdata;
        end
        @(posedge clk); #1;
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        if (k == lat) break;
      end
      if (lat <= TIMEOUT) begin
        exp_rdata = (ins.rd && !ins.wr) ? rdata : '0;
        check("done_wbv",   wb_valid,      1);
        check("done_rw",    wb_reg_write,  ins.rw);
        check("done_m2r",   wb_mem_to_reg, ins.m2r);
        check("done_wreg",  wb_write_reg,  ins.wreg);
        check("done_alu",   wb_alu_result, ins.alu);
        check("done_rdata", wb_read_data,  exp_rdata);
        check("done_buserr", bus_err,      0);
      end else begin
        check("tmo_wbv",    wb_valid,     1);
        check("tmo_rw",     wb_reg_write, 0);
        check("tmo_buserr", bus_err,      1);
      end
      check("mem_misalign", misalign_err, 0);
    end else if (is_mem) begin
      check("mis_wbv",      wb_valid,     1);
      check("mis_rw",       wb_reg_write, 0);
      check("mis_err",      misalign_err, 1);
      check("mis_buserr",   bus_err,      0);
    end else if (ins.valid) begin
      check("alu_wbv",      wb_valid,      1);
      check("alu_rw",       wb_reg_write,  ins.rw);
      check("alu_m2r",      wb_mem_to_reg, ins.m2r);
      check("alu_wreg",     wb_write_reg,  ins.wreg);
      check("alu_alu",      wb_alu_result, ins.alu);
      check("alu_rdata",    wb_read_data,  0);
      check("alu_errs",     {misalign_err, bus_err}, 0);
    end else begin
      check("bub_wbv",      wb_valid,     0);
      check("bub_rw",       wb_reg_write, 0);
      check("bub_fields",   {wb_mem_to_reg, wb_write_reg}, 0);
      check("bub_alu",      wb_alu_result, 0);
      check("bub_rdata",    wb_read_data,  0);
      check("bub_errs",     {misalign_err, bus_err}, 0);
    end
    check("post_stall", mem_stall, 0);
    check("post_req",   dmem_req,  0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {mem_stall, dmem_req, dmem_we, wb_valid, wb_reg_write,
                          wb_mem_to_reg, misalign_err, bus_err}, 0);
    check({tag, "_addr"},  dmem_addr,     0);
    check({tag, "_wdata"}, dmem_wdata,    0);
    check({tag, "_wreg"},  wb_write_reg,  0);
    check({tag, "_alu"},   wb_alu_result, 0);
    check({tag, "_rdata"}, wb_read_data,  0);
  endtask

  initial begin
    instr_t ins;
    int     lat;

    // Reset held two cycles with a live instruction on the inputs.
    reset      = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    drive(mk(1, 32'h0000_00AA, 32'h5, 5'd9, 0, 0, 0, 1));
    @(posedge clk); #1; check_all_zero("rst1");
    @(posedge clk); #1; check_all_zero("rst2");
    reset = 1'b0;

    // Directed sequence from the test plan.
    step(mk(1, 32'h0000_00AA, 32'h0,    5'd9,  0, 0, 0, 1), 1, '0);
    step(mk(1, 32'h0000_0100, 32'h0,    5'd4,  1, 0, 1, 1), 3, 32'hDEAD_BEEF);
    step(mk(1, 32'h0000_0204, 32'h1234, 5'd0,  0, 1, 0, 0), 1, 32'hFFFF_FFFF);
    step(mk(1, 32'h0000_0055, 32'h0,    5'd7,  0, 0, 0, 1), 1, '0);
    step(mk(1, 32'h0000_0102, 32'h0,    5'd3,  1, 0, 1, 1), 1, '0);
    step(mk(1, 32'h0000_0300, 32'h0,    5'd5,  1, 0, 1, 1), TIMEOUT + 5, '0);
    step(mk(1, 32'h0000_0304, 32'h0,    5'd6,  1, 0, 1, 1), TIMEOUT, 32'hCAFE_F00D);
    step(mk(1, 32'h0000_0408, 32'h9999, 5'd8,  1, 1, 0, 1), 2, 32'h1111_2222);
    step(mk(0, 32'h0000_0500, 32'h0,    5'd1,  1, 0, 1, 1), 1, '0);

    // Reset on the second WAIT cycle; a later ack must not retire anything.
    drive(mk(1, 32'h0000_0600, 32'h0, 5'd2, 1, 0, 1, 1));
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    check("rw_req1", dmem_req, 1);
    @(posedge clk); #1;
    check("rw_req2", dmem_req, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rw_req_drop", dmem_req,  0);
    check("rw_stall",    mem_stall, 0);
    check("rw_wbv",      wb_valid,  0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("rw_late_wbv", wb_valid,    0);
    check("rw_late_rd",  wb_read_data, 0);
    @(posedge clk); #1;
    check("rw_late_wbv2", wb_valid, 0);
    check("rw_late_req",  dmem_req, 0);

    // Random instructions with random latencies, including timeouts.
    for (int n = 0; n < 300; n++) begin
      ins = rand_instr();
      lat = $urandom_range(1, TIMEOUT + 2);
      step(ins, lat, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
